// File: rtl/synth_env_pkg.sv
// Shared types and helpers for the ADSR envelope generator.
package synth_env_pkg;

    localparam int ACC_W_DEF   = 16;
    localparam int LEVEL_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    typedef enum logic {
        STEP_ADD = 1'b0,
        STEP_SUB = 1'b1
    } step_mode_e;

    // A rate of N advances the accumulator by N+1, so rate 0 still moves.
    function automatic logic [8:0] rate_to_step(input logic [7:0] rate);
        return {1'b0, rate} + 9'd1;
    endfunction

endpackage

// File: rtl/adsr_envelope_if.sv
// Control and level bus of one envelope voice.
interface adsr_envelope_if
    import synth_env_pkg::*;
#(
    parameter int LEVEL_W = LEVEL_W_DEF
) ();
    logic               tick;
    logic               gate;
    logic [7:0]         attack_rate;
    logic [7:0]         decay_rate;
    logic [7:0]         sustain_level;
    logic [7:0]         release_rate;
    logic [LEVEL_W-1:0] level;
    logic               level_valid;
    logic               active;
    logic [2:0]         state;

    modport master (
        output tick, gate, attack_rate, decay_rate, sustain_level, release_rate,
        input  level, level_valid, active, state
    );

    modport slave (
        input  tick, gate, attack_rate, decay_rate, sustain_level, release_rate,
        output level, level_valid, active, state
    );
endinterface

// File: rtl/env_step_unit.sv
// Saturating accumulator step: add toward full scale or subtract toward a
// floor target. Arithmetic is one bit wider than the accumulator so the
// carry/borrow is explicit and nothing wraps.
module env_step_unit
    import synth_env_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [8:0]       step,
    input  logic [ACC_W-1:0] target,
    input  step_mode_e       mode,
    output logic [ACC_W-1:0] next_acc,
    output logic             reached
);
    logic [ACC_W:0] step_x;
    logic [ACC_W:0] sum;
    logic [ACC_W:0] diff;

    assign step_x = {{(ACC_W-8){1'b0}}, step};
    assign sum    = {1'b0, acc} + step_x;
    assign diff   = {1'b0, acc} - step_x;

    // Clamp at full scale when adding, at the target when subtracting.
    always_comb begin
        reached  = 1'b0;
        next_acc = acc;
        if (mode == STEP_ADD) begin
            reached  = sum[ACC_W] | (&sum[ACC_W-1:0]);
            next_acc = reached ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end else begin
            reached  = diff[ACC_W] | (diff[ACC_W-1:0] <= target);
            next_acc = reached ? target : diff[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator for one voice; level feeds the 8-bit multiplier
// operand. Optional macro ADSR_RETRIGGER_EN: gate rising edge zeroes the
// accumulator (hard retrigger) instead of restarting legato.
//
// state   | meaning
// IDLE    | no note, acc held at 0
// ATTACK  | ramp up by attack step per tick until full scale
// DECAY   | ramp down by decay step per tick until sustain target
// SUSTAIN | acc tracks live sustain target every tick
// RELEASE | ramp down by release step per tick until 0
module adsr_envelope
    import synth_env_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int LEVEL_W = LEVEL_W_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    adsr_envelope_if.slave bus
);
    env_state_e         state_q;
    logic               gate_q;
    logic [ACC_W-1:0]   acc;
    logic [LEVEL_W-1:0] level_q;
    logic               level_valid_q;
    logic               active_q;

    logic               rise;
    logic               fall;
    logic [8:0]         step;
    step_mode_e         mode;
    logic [ACC_W-1:0]   target;
    logic [ACC_W-1:0]   sustain_tgt;
    logic [ACC_W-1:0]   step_next;
    logic               reached;

    assign rise        = bus.gate & ~gate_q;
    assign fall        = ~bus.gate & gate_q;
    assign sustain_tgt = {bus.sustain_level, {(ACC_W-8){1'b0}}};

    // Pick step size, direction and floor for the current phase.
    always_comb begin
        step   = rate_to_step(bus.attack_rate);
        mode   = STEP_ADD;
        target = '0;
        case (state_q)
            ST_DECAY: begin
                step   = rate_to_step(bus.decay_rate);
                mode   = STEP_SUB;
                target = sustain_tgt;
            end
            ST_RELEASE: begin
                step   = rate_to_step(bus.release_rate);
                mode   = STEP_SUB;
                target = '0;
            end
            default: ;
        endcase
    end

    env_step_unit #(.ACC_W(ACC_W)) u_step (
        .acc      (acc),
        .step     (step),
        .target   (target),
        .mode     (mode),
        .next_acc (step_next),
        .reached  (reached)
    );

    // Envelope FSM; a gate edge takes priority over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            gate_q        <= 1'b0;
            acc           <= '0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            gate_q        <= bus.gate;
            level_valid_q <= 1'b0;
            if (rise) begin
                state_q  <= ST_ATTACK;
                active_q <= 1'b1;
`ifdef ADSR_RETRIGGER_EN
                acc      <= '0;
                level_q  <= '0;
`endif
            end else if (fall) begin
                if (state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})
                    state_q <= ST_RELEASE;
            end else if (bus.tick) begin
                level_valid_q <= 1'b1;
                case (state_q)
                    ST_ATTACK: begin
                        acc     <= step_next;
                        level_q <= step_next[ACC_W-1 -: LEVEL_W];
                        if (reached) state_q <= ST_DECAY;
                    end
                    ST_DECAY: begin
                        acc     <= step_next;
                        level_q <= step_next[ACC_W-1 -: LEVEL_W];
                        if (reached) state_q <= ST_SUSTAIN;
                    end
                    ST_SUSTAIN: begin
                        acc     <= sustain_tgt;
                        level_q <= sustain_tgt[ACC_W-1 -: LEVEL_W];
                    end
                    ST_RELEASE: begin
                        acc     <= step_next;
                        level_q <= step_next[ACC_W-1 -: LEVEL_W];
                        if (reached) begin
                            state_q  <= ST_IDLE;
                            active_q <= 1'b0;
                        end
                    end
                    default: begin
                        acc     <= '0;
                        level_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.level       = level_q;
    assign bus.level_valid = level_valid_q;
    assign bus.active      = active_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: a behavioural integer model predicts
// level/state for every tick, and a negedge monitor checks each level_valid.
module tb_adsr_envelope;

    typedef struct {
        int lvl;
        int st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t exp_q[$];

    int m_acc = 0;
    int m_state = 0;
    bit m_gate_q = 1'b0;

    adsr_envelope_if bus ();

    adsr_envelope dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: applies one clock of stimulus, queues expected output.
    task automatic model_apply(input bit t, input bit g);
        int step;
        int s;
        exp_t e;
        if (g && !m_gate_q) begin
            m_state = 1;
`ifdef ADSR_RETRIGGER_EN
            m_acc = 0;
`endif
        end else if (!g && m_gate_q) begin
            if (m_state >= 1 && m_state <= 3) m_state = 4;
        end else if (t) begin
            case (m_state)
                1: begin
                    step = int'(bus.attack_rate) + 1;
                    m_acc = m_acc + step;
                    if (m_acc >= 65535) begin m_acc = 65535; m_state = 2; end
                end
                2: begin
                    step = int'(bus.decay_rate) + 1;
                    s = int'(bus.sustain_level) * 256;
                    m_acc = m_acc - step;
                    if (m_acc <= s) begin m_acc = s; m_state = 3; end
                end
                3: m_acc = int'(bus.sustain_level) * 256;
                4: begin
                    step = int'(bus.release_rate) + 1;
                    if (m_acc <= step) begin m_acc = 0; m_state = 0; end
                    else m_acc = m_acc - step;
                end
                default: m_acc = 0;
            endcase
            e.lvl = m_acc / 256;
            e.st  = m_state;
            exp_q.push_back(e);
        end
        m_gate_q = g;
    endtask

    task automatic drive(input bit t, input bit g);
        bus.tick = t;
        bus.gate = g;
        model_apply(t, g);
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
    endtask

    // Scoreboard consumer: every level_valid pulse must match the next expectation.
    always @(negedge clk) begin
        if (rst_n && bus.level_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_valid: level_valid high with no expected tick, level=%0h", bus.level);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (bus.level !== e.lvl[7:0]) begin
                    n_fail++;
                    $display("FAIL sb_level: got %0h expected %0h", bus.level, e.lvl);
                end
                n_checks++;
                if (bus.state !== e.st[2:0]) begin
                    n_fail++;
                    $display("FAIL sb_state: got %0d expected %0d", bus.state, e.st);
                end
            end
        end
    end

    task automatic check_now(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic test_reset();
        #1;
        check_now("reset_level", int'(bus.level), 0);
        check_now("reset_valid", int'(bus.level_valid), 0);
        check_now("reset_active", int'(bus.active), 0);
        check_now("reset_state", int'(bus.state), 0);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0);
        check_now("idle_tick_state", int'(bus.state), 0);
    endtask

    task automatic test_attack();
        bus.attack_rate = 8'd255;
        drive(1'b0, 1'b1);
        check_now("attack_enter_state", int'(bus.state), 1);
        check_now("attack_enter_active", int'(bus.active), 1);
        for (int i = 0; i < 255; i++) drive(1'b1, 1'b1);
        check_now("attack_255_level", int'(bus.level), 8'hFF);
        check_now("attack_255_state", int'(bus.state), 1);
        drive(1'b1, 1'b1);
        check_now("attack_peak_state", int'(bus.state), 2);
        check_now("attack_peak_acc", int'(dut.acc), 16'hFFFF);
    endtask

    task automatic test_decay();
        bus.decay_rate    = 8'd255;
        bus.sustain_level = 8'h80;
        for (int i = 0; i < 127; i++) drive(1'b1, 1'b1);
        check_now("decay_127_state", int'(bus.state), 2);
        check_now("decay_127_acc", int'(dut.acc), 16'h80FF);
        drive(1'b1, 1'b1);
        check_now("decay_128_state", int'(bus.state), 3);
        check_now("decay_128_acc", int'(dut.acc), 16'h8000);
    endtask

    task automatic test_sustain_live();
        drive(1'b1, 1'b1);
        bus.sustain_level = 8'h90;
        drive(1'b1, 1'b1);
        check_now("sustain_live_level", int'(bus.level), 8'h90);
        bus.sustain_level = 8'h80;
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        check_now("sustain_back_level", int'(bus.level), 8'h80);
    endtask

    task automatic test_edge_tick();
        bus.release_rate = 8'd255;
        drive(1'b1, 1'b0);
        check_now("edge_tick_state", int'(bus.state), 4);
        check_now("edge_tick_acc", int'(dut.acc), 16'h8000);
        check_now("edge_tick_valid", int'(bus.level_valid), 0);
    endtask

    task automatic test_release();
        for (int i = 0; i < 127; i++) drive(1'b1, 1'b0);
        check_now("release_127_acc", int'(dut.acc), 16'h0100);
        check_now("release_127_state", int'(bus.state), 4);
        drive(1'b1, 1'b0);
        check_now("release_128_acc", int'(dut.acc), 0);
        check_now("release_128_state", int'(bus.state), 0);
        check_now("release_128_active", int'(bus.active), 0);
    endtask

    task automatic test_regate();
        int want;
        drive(1'b0, 1'b1);
        for (int i = 0; i < 64; i++) drive(1'b1, 1'b1);
        check_now("regate_pre_level", int'(bus.level), 8'h40);
        drive(1'b0, 1'b0);
        check_now("regate_fall_state", int'(bus.state), 4);
        drive(1'b0, 1'b1);
`ifdef ADSR_RETRIGGER_EN
        want = 0;
`else
        want = 8'h40;
`endif
        check_now("regate_level", int'(bus.level), want);
        check_now("regate_state", int'(bus.state), 1);
        for (int i = 0; i < 300 && m_state == 1; i++) drive(1'b1, 1'b1);
        check_now("regate_peak_state", int'(bus.state), 2);
    endtask

    task automatic test_sustain_ff();
        bus.sustain_level = 8'hFF;
        drive(1'b1, 1'b1);
        check_now("sustain_ff_state", int'(bus.state), 3);
        check_now("sustain_ff_acc", int'(dut.acc), 16'hFF00);
    endtask

    task automatic test_async_reset();
        bus.sustain_level = 8'h10;
        bus.decay_rate    = 8'd15;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        for (int i = 0; i < 300 && m_state == 1; i++) drive(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
        check_now("pre_reset_state", int'(bus.state), 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_now("async_level", int'(bus.level), 0);
        check_now("async_valid", int'(bus.level_valid), 0);
        check_now("async_active", int'(bus.active), 0);
        check_now("async_state", int'(bus.state), 0);
        m_acc = 0;
        m_state = 0;
        m_gate_q = 1'b0;
        bus.gate = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(1'b0, 1'b1);
        check_now("reset_exit_rise_state", int'(bus.state), 1);
    endtask

    initial begin
        bus.tick          = 1'b0;
        bus.gate          = 1'b0;
        bus.attack_rate   = 8'd0;
        bus.decay_rate    = 8'd0;
        bus.sustain_level = 8'd0;
        bus.release_rate  = 8'd0;
        test_reset();
        test_attack();
        test_decay();
        test_sustain_live();
        test_edge_tick();
        test_release();
        test_regate();
        test_sustain_ff();
        test_async_reset();
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_missing_valid: %0d expected ticks never produced level_valid, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

ADSR envelope generator for one synth voice. Runs from a sample-rate tick and produces the 8-bit amplitude word that drives the multiplier's 8-bit `b` operand; the oscillator's 20-bit sample drives the 20-bit operand. The 28-bit product is the enveloped voice sample. The block owns the gate-driven attack/decay/sustain/release state machine and a saturating 16-bit level accumulator.

## Interface
Parameters:
- `ACC_W`, 16, accumulator width; must be at least `LEVEL_W` + 8.
- `LEVEL_W`, 8, output level width; must equal the multiplier's `b` width.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `tick`, in, 1: one-cycle sample-rate strobe.
- `gate`, in, 1: key held; sampled every clock.
- `attack_rate`, in, 8: attack step is `attack_rate + 1` per tick.
- `decay_rate`, in, 8: decay step is `decay_rate + 1` per tick.
- `sustain_level`, in, 8: sustain target is `{sustain_level, 8'h00}`.
- `release_rate`, in, 8: release step is `release_rate + 1` per tick.
- `level`, out, `LEVEL_W`: `acc[ACC_W-1 -: LEVEL_W]`, registered.
- `level_valid`, out, 1: one-cycle pulse when `level` has been updated by a tick.
- `active`, out, 1: high in any state other than IDLE.
- `state`, out, 3: current state code.

## Operation
- States and codes: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- Gate edge detection uses a registered copy `gate_q`.
- Gate rising edge, from any state: go to ATTACK. The accumulator is kept (legato restart).
- Gate falling edge in ATTACK, DECAY or SUSTAIN: go to RELEASE, accumulator kept.
- Accumulator updates happen only on cycles where `tick` is high. All arithmetic is 17 bits wide with an explicit carry or borrow check, and results saturate. Nothing wraps.
  - ATTACK: `acc += step`. If the result is ≥ `2^ACC_W-1`, set `acc` to all-ones and go to DECAY.
  - DECAY: `acc -= step`. If the result is ≤ S, or it borrows, set `acc` to S and go to SUSTAIN.
  - If S = 0xFFFF-class, i.e. `sustain_level` = 0xFF: DECAY still takes one tick and clamps to 0xFF00.
  - SUSTAIN: `acc` follows S every tick, so live `sustain_level` changes take effect.
  - RELEASE: if `acc` ≤ step, set `acc` to 0 and go to IDLE; otherwise `acc -= step`.
  - IDLE: `acc` holds at 0.
- A gate edge in the same cycle as `tick`: the edge wins. The state changes and there is no accumulator step that cycle, and `level_valid` stays low.
- Rate and sustain inputs are sampled on the tick cycle. No holding registers.

## Timing
- Reset values: `level`=0, `level_valid`=0, `active`=0, `state`=IDLE, `acc`=0, `gate_q`=0.
- `rst_n` low at any time, including mid-envelope, clears everything immediately. Leaving reset with `gate` already high counts as a rising edge on the first clock.
- Latency: `level` and `level_valid` update on the clock edge that samples `tick`, and are visible the next cycle.
- `state` and `active` change on the clock edge that samples a gate edge or a terminal tick.
- Minimum spacing between ticks is 1 clock; back-to-back ticks are legal.

## Configuration
- `ADSR_RETRIGGER_EN` defined: a gate rising edge forces `acc` to 0 as it enters ATTACK (hard retrigger), and `level` reads 0 on the next cycle.
- Undefined: legato restart from the current `acc`, as described in Operation.

## Structure
- Package `synth_env_pkg` holds:
  - the state enum and its codes;
  - `ACC_W_DEF` = 16 and `LEVEL_W_DEF` = 8;
  - the rate-to-step helper function.
- Sub-module `env_step_unit`: a combinational saturating add/subtract-with-clamp. It takes `acc`, `step`, target and mode, and returns `next_acc` and a `reached` flag. The FSM and registers stay in `adsr_envelope`.

## Test plan
- Attack to peak: reset, `attack_rate`=255, gate rises, continuous ticks. `level` must go 0x01, 0x02, … up to 0xFF on tick 256, and `state` must reach DECAY on that tick.
- Decay to sustain: `decay_rate`=255, `sustain_level`=0x80, starting from `acc`=0xFFFF. `acc` must clamp to 0x8000 and enter SUSTAIN on decay tick 128.
- Release to idle: from SUSTAIN at 0x8000, `release_rate`=255, gate falls. After 127 ticks `acc` is 0x0100. Tick 128 gives `acc`=0, `state`=IDLE, `active`=0.
- Simultaneous gate edge and tick in SUSTAIN: `state` goes to RELEASE, `acc` is unchanged that cycle, and `level_valid` stays low.
- Mid-attack re-gate at `level`=0x40: without the macro, ATTACK continues from 0x40. With `ADSR_RETRIGGER_EN`, `level`=0x00 on the next cycle.
- Async reset mid-decay: drop `rst_n` with no clock edge. All outputs go to their reset values immediately.
